// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: reset/bubble constants, fetch FSM states
// and the IF->DE/EX pipeline register layout.
package rv32_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } if_pp_t;

endpackage

// File: rtl/if_pp_reg.sv
// IF->DE/EX pipeline register. Priority: flush > load > stall (hold) > bubble.
module if_pp_reg #(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] ld_pc,
  input  logic [31:0]     ld_inst,
  output logic [XLEN-1:0] pp_pc,
  output logic [31:0]     pp_inst,
  output logic            pp_valid
);
  import rv32_pkg::*;

  if_pp_t pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp.pc    <= '0;
      pp.inst  <= NOP;
      pp.valid <= 1'b0;
    end else if (flush) begin
      pp.pc    <= '0;
      pp.inst  <= NOP;
      pp.valid <= 1'b0;
    end else if (load) begin
      pp.pc    <= ld_pc;
      pp.inst  <= ld_inst;
      pp.valid <= 1'b1;
    end else if (!stall) begin
      // bubble keeps the previous pc so downstream debug still sees a sane value
      pp.inst  <= NOP;
      pp.valid <= 1'b0;
    end
  end

  assign pp_pc    = pp.pc;
  assign pp_inst  = pp.inst;
  assign pp_valid = pp.valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues one imem request at a time, and feeds
// the IF->DE/EX register with flush squashing and a one-entry stall hold buffer.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INST = rv32_pkg::NOP_INST
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_stall,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic [XLEN-1:0] o_pc_pp,
  output logic [31:0]     o_inst_pp,
  output logic            o_valid_pp
);
  import rv32_pkg::*;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            drop, drop_nxt;
  logic [XLEN-1:0] hold_pc, hold_pc_nxt;
  logic [31:0]     hold_inst, hold_inst_nxt;

  logic            flush_act;
  logic            pp_load;
  logic [XLEN-1:0] pp_ld_pc;
  logic [31:0]     pp_ld_inst;

  assign flush_act   = i_flush && (state != S_BOOT);
  assign o_imem_req  = (state == S_REQ);
  assign o_imem_addr = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop      <= drop_nxt;
      hold_pc   <= hold_pc_nxt;
      hold_inst <= hold_inst_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_nxt      = drop;
    hold_pc_nxt   = hold_pc;
    hold_inst_nxt = hold_inst;
    pp_load       = 1'b0;
    pp_ld_pc      = pc;
    pp_ld_inst    = i_imem_rdata;

    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else if (!i_stall) begin
            pp_load   = 1'b1;
            pc_nxt    = pc + XLEN'(4);
            state_nxt = S_REQ;
          end else begin
            hold_pc_nxt   = pc;
            hold_inst_nxt = i_imem_rdata;
            pc_nxt        = pc + XLEN'(4);
            state_nxt     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          pp_load       = 1'b1;
          pp_ld_pc      = hold_pc;
          pp_ld_inst    = hold_inst;
          hold_pc_nxt   = '0;
          hold_inst_nxt = '0;
          state_nxt     = S_REQ;
        end
      end
      default: state_nxt = S_BOOT;
    endcase

    if (flush_act) begin
      pp_load       = 1'b0;
      pc_nxt        = i_br_target & ~XLEN'(3);
      hold_pc_nxt   = '0;
      hold_inst_nxt = '0;
      // A request issued this cycle (S_REQ) or still unanswered (S_WAIT) will
      // return a stale word; wait for it and throw it away before refetching.
      if ((state == S_REQ) || (state == S_WAIT && !i_imem_rvalid)) begin
        drop_nxt  = 1'b1;
        state_nxt = S_WAIT;
      end else begin
        drop_nxt  = 1'b0;
        state_nxt = S_REQ;
      end
    end
  end

  if_pp_reg #(
    .XLEN (XLEN),
    .NOP  (NOP_INST)
  ) u_if_pp_reg (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (flush_act),
    .stall    (i_stall),
    .load     (pp_load),
    .ld_pc    (pp_ld_pc),
    .ld_inst  (pp_ld_inst),
    .pp_pc    (o_pc_pp),
    .pp_inst  (o_inst_pp),
    .pp_valid (o_valid_pp)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized
// stall/flush/latency traffic against an in-order instruction-stream model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_br_target = '0;
  logic        i_stall = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_pc_pp;
  logic [31:0] o_inst_pp;
  logic        o_valid_pp;

  fetch_stage dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_br_target   (i_br_target),
    .i_stall       (i_stall),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc_pp       (o_pc_pp),
    .o_inst_pp     (o_inst_pp),
    .o_valid_pp    (o_valid_pp)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // model / memory state
  logic [31:0] exp_pc;       // next pc expected to reach the pipeline register
  logic        pend;         // memory response outstanding
  int          cnt;          // cycles until that response
  logic [31:0] resp_addr;
  int          lat = 1;
  int          ncyc;         // edges since reset release
  int          idle;
  int          ndeliv = 0;
  logic        last_req;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0003;
  endfunction

  task automatic model_reset();
    exp_pc = 32'h0; pend = 1'b0; cnt = 0; ncyc = 0; idle = 0;
    i_imem_rvalid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
  endtask

  task automatic rst_chk();
    chk("rst_req", {31'b0, o_imem_req}, 32'h0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_pc_pp", o_pc_pp, 32'h0);
    chk("rst_inst_pp", o_inst_pp, NOP);
    chk("rst_valid_pp", {31'b0, o_valid_pp}, 32'h0);
  endtask

  // One clock: drive memory + controls at negedge, check after the posedge.
  task automatic cycle(input logic st, input logic fl, input logic [31:0] tgt);
    logic        rv;
    logic [31:0] p_pc, p_inst;
    logic        p_valid, boot;
    @(negedge i_clk);
    p_pc = o_pc_pp; p_inst = o_inst_pp; p_valid = o_valid_pp;
    rv = pend && (cnt == 0);
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? mem_word(resp_addr) : 32'hDEAD_BEEF;
    if (rv) pend = 1'b0;
    else if (pend) cnt--;
    last_req = o_imem_req; last_addr = o_imem_addr;
    if (o_imem_req) begin
      chk("one_outstanding", {31'b0, pend}, 32'h0);
      chk("req_addr", o_imem_addr, exp_pc);
      pend = 1'b1; cnt = lat - 1; resp_addr = o_imem_addr; idle = 0;
    end else begin
      idle++;
    end
    i_stall = st; i_flush = fl; i_br_target = tgt;
    boot = (ncyc == 0);
    @(posedge i_clk); #1;
    ncyc++;
    if (fl && !boot) begin
      chk("flush_pc", o_pc_pp, 32'h0);
      chk("flush_inst", o_inst_pp, NOP);
      chk("flush_valid", {31'b0, o_valid_pp}, 32'h0);
      exp_pc = tgt & 32'hFFFF_FFFC;
    end else if (st) begin
      chk("stall_hold", {o_pc_pp ^ o_inst_pp, 31'b0, o_valid_pp} == {p_pc ^ p_inst, 31'b0, p_valid}
          && o_pc_pp == p_pc, 32'h1);
    end else if (o_valid_pp) begin
      chk("deliv_pc", o_pc_pp, exp_pc);
      chk("deliv_inst", o_inst_pp, mem_word(exp_pc));
      exp_pc = exp_pc + 32'h4;
      ndeliv++;
    end else begin
      chk("bubble_inst", o_inst_pp, NOP);
      chk("bubble_pc", o_pc_pp, p_pc);
    end
    if (idle > 40) begin
      chk("progress_timeout", idle, 0);
      idle = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #2;
    rst_chk();
    model_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    model_reset();
    #12;
    rst_chk();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // boot + first two fetches with 1-cycle memory
    lat = 1;
    cycle(0, 0, 0); chk("boot_no_req", {31'b0, last_req}, 32'h0);
    cycle(0, 0, 0); chk("first_req", {31'b0, last_req}, 32'h1);
    chk("first_addr", last_addr, 32'h0);
    cycle(0, 0, 0); chk("first_pc", o_pc_pp, 32'h0);
    chk("first_inst", o_inst_pp, 32'h0000_0093);
    // stall while the 0x4 fetch is in flight
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0); chk("stall_no_req_a", {31'b0, last_req}, 32'h0);
    cycle(1, 0, 0); chk("stall_no_req_b", {31'b0, last_req}, 32'h0);
    cycle(0, 0, 0); chk("unstall_pc", o_pc_pp, 32'h4);
    chk("unstall_inst", o_inst_pp, 32'h0010_0113);
    lat = 2;
    cycle(0, 0, 0); chk("after_hold_addr", last_addr, 32'h8);
    // flush while waiting, stale word arrives later
    cycle(0, 1, 32'h100);
    cycle(0, 0, 0); chk("stale_dropped", {31'b0, o_valid_pp}, 32'h0);
    lat = 1;
    cycle(0, 0, 0); chk("redirect_addr", last_addr, 32'h100);
    // flush coincident with rvalid, and flush+stall together
    cycle(0, 1, 32'h40);
    cycle(0, 0, 0); chk("flush_rv_addr", last_addr, 32'h40);
    chk("flush_rv_valid", {31'b0, o_valid_pp}, 32'h0);
    cycle(1, 1, 32'hFFFF_FFFC);
    chk("flush_stall_inst", o_inst_pp, NOP);
    cycle(0, 0, 0); chk("wrap_addr_a", last_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0); chk("wrap_pc", o_pc_pp, 32'hFFFF_FFFC);
    cycle(0, 0, 0); chk("wrap_addr_b", last_addr, 32'h0);
    cycle(0, 1, 32'h103);
    cycle(0, 0, 0); chk("align_addr", last_addr, 32'h100);

    // flush in the boot cycle is ignored
    do_reset();
    cycle(0, 1, 32'h200);
    cycle(0, 0, 0); chk("boot_flush_ign", last_addr, 32'h0);
    chk("boot_flush_req", {31'b0, last_req}, 32'h1);

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      lat = $urandom_range(1, 3);
      case ($urandom_range(0, 3))
        0:       t = 32'hFFFF_FFFC;
        1:       t = $urandom_range(0, 255);
        default: t = $urandom;
      endcase
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), t);
    end
    chk("deliveries_min", {31'b0, ndeliv >= 100}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
